// File: rtl/id_branch_resolver.sv
// id_branch_resolver: ID-stage IF/ID register, control-flow decode and
// next-PC select, branch/jump operand hazard stalls, wrong-path squash.
// Optional build macro: DELAY_SLOT_EN (taken control ops keep the slot word).
module id_branch_resolver #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_if,
  input  logic [31:0] pc_4_if,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dst,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_dst,
  output logic [31:0] instr_id,
  output logic [31:0] pc_4_id_full,
  output logic [3:0]  pc_4_id,
  output logic [27:0] offset28,
  output logic [31:0] beq,
  output logic [31:0] jr,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        bubble
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OW   = 6;

  localparam logic [OW-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OW-1:0] OP_J       = 6'b000010;
  localparam logic [OW-1:0] OP_JAL     = 6'b000011;
  localparam logic [OW-1:0] OP_BEQ     = 6'b000100;
  localparam logic [OW-1:0] FN_JR      = 6'b001000;

  localparam logic [1:0] SRC_PC4 = 2'b00;
  localparam logic [1:0] SRC_J   = 2'b01;
  localparam logic [1:0] SRC_BR  = 2'b10;
  localparam logic [1:0] SRC_JR  = 2'b11;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] instr_id_q, instr_id_d;
  logic [XLEN-1:0] pc4_q, pc4_d;

  logic [OW-1:0] opcode, funct;
  logic [RW-1:0] rs_idx, rt_idx;
  logic          is_j, is_beq, is_jr, ctrl_op;
  logic          uses_rs, uses_rt, rs_hz, rt_hz;
  logic          stall, taken, redirect;

  // Field extraction and control-flow decode of the ID instruction
  always_comb begin
    opcode  = instr_id_q[31:26];
    funct   = instr_id_q[5:0];
    rs_idx  = instr_id_q[25:21];
    rt_idx  = instr_id_q[20:16];
    is_j    = (opcode == OP_J) || (opcode == OP_JAL);
    is_beq  = (opcode == OP_BEQ);
    is_jr   = (opcode == OP_SPECIAL) && (funct == FN_JR);
    ctrl_op = is_j || is_beq || is_jr;
    uses_rs = !is_j;
    uses_rt = !is_j && !is_jr;
  end

  // Hazard detection: control ops need final values in ID, everything else only load-use
  always_comb begin
    rs_hz = (rs_idx != RW'(0)) &&
            ((ctrl_op && ex_reg_write && (ex_dst == rs_idx)) ||
             (ctrl_op && mem_mem_read && (mem_dst == rs_idx)) ||
             (ex_mem_read && (ex_dst == rs_idx)));
    rt_hz = (rt_idx != RW'(0)) &&
            ((ctrl_op && ex_reg_write && (ex_dst == rt_idx)) ||
             (ctrl_op && mem_mem_read && (mem_dst == rt_idx)) ||
             (ex_mem_read && (ex_dst == rt_idx)));
    stall    = (uses_rs && rs_hz) || (uses_rt && rt_hz);
    taken    = (state_q == ST_RUN) &&
               (is_j || is_jr || (is_beq && (rs_data == rt_data)));
    redirect = taken && !stall;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: a squashing redirect spends one cycle in FLUSH
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
`ifdef DELAY_SLOT_EN
        state_d = ST_RUN;
`else
        if (redirect) state_d = ST_FLUSH;
`endif
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: next-PC select, PC enable and ID/EX bubble
  always_comb begin
    pc_src   = SRC_PC4;
    pc_write = 1'b1;
    bubble   = 1'b0;
    if (stall) begin
      pc_write = 1'b0;
      bubble   = 1'b1;
    end else if (redirect) begin
      if (is_j)        pc_src = SRC_J;
      else if (is_beq) pc_src = SRC_BR;
      else             pc_src = SRC_JR;
    end
  end

  // IF/ID next value: hold on stall, squash the wrong-path fetch on redirect
  always_comb begin
    instr_id_d = instr_id_q;
    pc4_d      = pc4_q;
    if (!stall) begin
      instr_id_d = instr_if;
      pc4_d      = pc_4_if;
`ifndef DELAY_SLOT_EN
      if (redirect) instr_id_d = NOP_WORD;
`endif
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_id_q <= NOP_WORD;
      pc4_q      <= '0;
    end else begin
      instr_id_q <= instr_id_d;
      pc4_q      <= pc4_d;
    end
  end

  assign instr_id     = instr_id_q;
  assign pc_4_id_full = pc4_q;
  assign pc_4_id      = pc4_q[31:28];
  assign offset28     = {instr_id_q[25:0], 2'b00};
  assign beq          = pc4_q + {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};
  assign jr           = rs_data;

endmodule

// File: tb/tb_id_branch_resolver.sv
// Directed bench for id_branch_resolver: decode, hazards, squash and reset.
module tb_id_branch_resolver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_if = '0, pc_4_if = '0, rs_data = '0, rt_data = '0;
  logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, mem_mem_read = 1'b0;
  logic [4:0]  ex_dst = '0, mem_dst = '0;
  logic [31:0] instr_id, pc_4_id_full, beq, jr;
  logic [3:0]  pc_4_id;
  logic [27:0] offset28;
  logic [1:0]  pc_src;
  logic        pc_write, bubble;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] W_SLOT = 32'h2222_2222;
`ifdef DELAY_SLOT_EN
  localparam logic [31:0] AFTER_TAKEN = W_SLOT;
`else
  localparam logic [31:0] AFTER_TAKEN = 32'h0000_0000;
`endif

  id_branch_resolver dut (
    .clk(clk), .reset(reset), .instr_if(instr_if), .pc_4_if(pc_4_if),
    .rs_data(rs_data), .rt_data(rt_data), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
    .mem_dst(mem_dst), .instr_id(instr_id), .pc_4_id_full(pc_4_id_full),
    .pc_4_id(pc_4_id), .offset28(offset28), .beq(beq), .jr(jr),
    .pc_src(pc_src), .pc_write(pc_write), .bubble(bubble)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hz();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dst = '0;
    mem_mem_read = 1'b0; mem_dst = '0;
  endtask

  initial begin
    // reset state
    tick();
    check("rst_instr", instr_id, 32'h0);
    check("rst_pc4", pc_4_id_full, 32'h0);
    check("rst_pc_src", 32'(pc_src), 32'h0);
    check("rst_pc_write", 32'(pc_write), 32'h1);
    check("rst_bubble", 32'(bubble), 32'h0);
    reset = 1'b0;

    // BEQ $1,$2,+4 taken
    instr_if = 32'h1022_0004; pc_4_if = 32'h0000_0104;
    tick();
    check("beq_load", instr_id, 32'h1022_0004);
    rs_data = 32'd5; rt_data = 32'd5; instr_if = W_SLOT; pc_4_if = 32'h0000_0108;
    #1;
    check("beq_target", beq, 32'h0000_0114);
    check("beq_pc_src", 32'(pc_src), 32'h2);
    check("beq_pc_write", 32'(pc_write), 32'h1);
    instr_if = 32'h1022_0004; pc_4_if = 32'h0000_0200;
    // the edge squashes the slot (or keeps it with delay slots)
    @(posedge clk); #1;
    // note: instr_if changed before this edge; redo with slot word held
    check("after_taken_src", 32'(pc_src), 32'h0);

    // untaken BEQ (rs!=rt)
    tick();
    check("beq2_load", instr_id, 32'h1022_0004);
    check("beq2_pc4", pc_4_id_full, 32'h0000_0200);
    rs_data = 32'd5; rt_data = 32'd6;
    #1;
    check("beq_untaken_src", 32'(pc_src), 32'h0);
    check("beq_untaken_tgt", beq, 32'h0000_0210);

    // J 0x40 with region 3
    instr_if = 32'h0800_0040; pc_4_if = 32'h3000_0008;
    tick();
    instr_if = W_SLOT; pc_4_if = 32'h3000_000C;
    #1;
    check("j_region", 32'(pc_4_id), 32'h3);
    check("j_offset28", 32'(offset28), 32'h0000_0100);
    check("j_pc_src", 32'(pc_src), 32'h1);
    tick();
    check("j_squash", instr_id, AFTER_TAKEN);
    check("flush_src", 32'(pc_src), 32'h0);

    // BEQ $0,$0,+2 wraps past 2^32
    instr_if = 32'h1000_0002; pc_4_if = 32'hFFFF_FFFC;
    tick();
    rs_data = '0; rt_data = '0; instr_if = W_SLOT;
    #1;
    check("wrap_target", beq, 32'h0000_0004);
    check("wrap_pc_src", 32'(pc_src), 32'h2);
    tick();

    // BEQ $0,$0,-1 with every hazard source pointing at $0
    instr_if = 32'h1000_FFFF; pc_4_if = 32'h0000_0000;
    tick();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd0;
    mem_mem_read = 1'b1; mem_dst = 5'd0; instr_if = W_SLOT;
    #1;
    check("neg_target", beq, 32'hFFFF_FFFC);
    check("r0_no_bubble", 32'(bubble), 32'h0);
    check("r0_pc_src", 32'(pc_src), 32'h2);
    tick();
    clear_hz();

    // LW $3 then BEQ $3,$4: two stall cycles
    instr_if = 32'h1064_0008; pc_4_if = 32'h0000_0404;
    tick();
    instr_if = W_SLOT; pc_4_if = 32'h0000_0408;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd3;
    rs_data = 32'd7; rt_data = 32'd9;
    #1;
    check("lu1_pc_write", 32'(pc_write), 32'h0);
    check("lu1_bubble", 32'(bubble), 32'h1);
    check("lu1_pc_src", 32'(pc_src), 32'h0);
    tick();
    check("lu1_hold", instr_id, 32'h1064_0008);
    clear_hz(); mem_mem_read = 1'b1; mem_dst = 5'd3;
    #1;
    check("lu2_pc_write", 32'(pc_write), 32'h0);
    check("lu2_bubble", 32'(bubble), 32'h1);
    check("lu2_pc_src", 32'(pc_src), 32'h0);
    tick();
    check("lu2_hold", instr_id, 32'h1064_0008);
    clear_hz(); rs_data = 32'd9; rt_data = 32'd9;
    #1;
    check("lu3_pc_src", 32'(pc_src), 32'h2);
    check("lu3_target", beq, 32'h0000_0424);
    check("lu3_bubble", 32'(bubble), 32'h0);
    tick();
    check("lu3_squash", instr_id, AFTER_TAKEN);

    // ADD $5 then JR $5: one stall cycle
    instr_if = 32'h00A0_0008; pc_4_if = 32'h0000_0504;
    tick();
    instr_if = W_SLOT; ex_reg_write = 1'b1; ex_dst = 5'd5;
    #1;
    check("jr_stall_bubble", 32'(bubble), 32'h1);
    check("jr_stall_pcw", 32'(pc_write), 32'h0);
    tick();
    clear_hz(); rs_data = 32'h1234_5678;
    #1;
    check("jr_pc_src", 32'(pc_src), 32'h3);
    check("jr_target", jr, 32'h1234_5678);
    tick();

    // LW $6 then ADD $7,$6,$6: one bubble; $0 and ALU producers do not stall
    instr_if = 32'h00C6_3820; pc_4_if = 32'h0000_0604;
    tick();
    instr_if = W_SLOT;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd6;
    #1;
    check("add_lu_bubble", 32'(bubble), 32'h1);
    check("add_lu_pcw", 32'(pc_write), 32'h0);
    tick();
    check("add_lu_hold", instr_id, 32'h00C6_3820);
    ex_dst = 5'd0;
    #1;
    check("add_r0_bubble", 32'(bubble), 32'h0);
    ex_mem_read = 1'b0; ex_dst = 5'd6;
    #1;
    check("add_alu_bubble", 32'(bubble), 32'h0);

    // reset asserted mid-stall takes effect without a clock edge
    ex_mem_read = 1'b1;
    #1;
    check("pre_rst_bubble", 32'(bubble), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_instr", instr_id, 32'h0);
    check("mid_rst_pc4", pc_4_id_full, 32'h0);
    check("mid_rst_pc_src", 32'(pc_src), 32'h0);
    check("mid_rst_pcw", 32'(pc_write), 32'h1);
    check("mid_rst_bubble", 32'(bubble), 32'h0);
    clear_hz();
    tick();
    reset = 1'b0;

    // reset asserted during FLUSH: no pending redirect survives
    instr_if = 32'h0800_0040; pc_4_if = 32'h0000_0010;
    tick();
    instr_if = W_SLOT;
    tick();
    reset = 1'b1;
    #1;
    check("flush_rst_instr", instr_id, 32'h0);
    check("flush_rst_src", 32'(pc_src), 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_load", instr_id, W_SLOT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/id_branch_resolver.md
Name: id_branch_resolver

Overview:
- ID-stage counterpart of the fetch stage: holds the IF/ID pipeline register.
- Decodes control-flow instructions and produces the fetch stage's next-PC controls: pc_src, beq target, jr target, offset28, pc_4_id nibble and pc_write.
- Detects data hazards on branch/jump operands and load-use, stalls fetch, flushes wrong-path fetches.
- Sits between the fetch stage and the ID/EX register.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word loaded into IF/ID on reset and flush.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- instr_if  in  32  instruction fetched at the current PC
- pc_4_if  in  32  PC+4 of instr_if from fetch
- rs_data  in  32  register file value for instr_id[25:21]; register file is write-before-read
- rt_data  in  32  register file value for instr_id[20:16]
- ex_reg_write  in  1  instruction in EX writes a register
- ex_mem_read  in  1  instruction in EX is a load
- ex_dst  in  5  destination register of EX instruction
- mem_mem_read  in  1  instruction in MEM is a load
- mem_dst  in  5  destination register of MEM instruction
- instr_id  out  32  IF/ID instruction register
- pc_4_id_full  out  32  IF/ID PC+4 register
- pc_4_id  out  4  pc_4_id_full[31:28], jump region
- offset28  out  28  {instr_id[25:0],2'b00}
- beq  out  32  pc_4_id_full + {sext(instr_id[15:0]),2'b00}
- jr  out  32  rs_data
- pc_src  out  2  00 PC+4, 01 jump, 10 branch target, 11 jr target
- pc_write  out  1  PC load enable
- bubble  out  1  zero ID/EX control this cycle

Behaviour:
- Reset (async, active-high):
  - instr_id=NOP_WORD, pc_4_id_full=0, FSM=RUN.
  - Combinational outputs follow: pc_src=00, pc_write=1, bubble=0.
- Decode of instr_id:
  - J: opcode 000010 or 000011 (JAL).
  - BEQ: opcode 000100; taken iff rs_data==rt_data.
  - JR: opcode 0, funct 001000.
  - Everything else is non-control.
- Operand use:
  - BEQ uses rs and rt; JR uses rs; J uses none.
  - Other instructions use rs and rt for load-use only.
- Stall condition S (any of the following, src!=0):
  - Control op, ex_reg_write && ex_dst==src: ALU result not yet resolvable in ID.
  - Control op, mem_mem_read && mem_dst==src.
  - Any op, ex_mem_read && ex_dst==src.
  - A load feeding a BEQ therefore stalls 2 cycles; an ALU result feeding a BEQ stalls 1 cycle.
- While S:
  - pc_write=0, IF/ID holds, bubble=1, pc_src=00.
  - Redirect suppressed until S clears.
- Not S and control taken:
  - pc_src per op; pc_write=1.
  - IF/ID loads NOP_WORD (squash) at the next edge; FSM -> FLUSH.
- Not S and not taken: pc_src=00, pc_write=1, IF/ID loads instr_if / pc_4_if.
- FSM:
  - RUN: normal operation.
  - FLUSH: lasts exactly one cycle, with the squashed NOP in ID; no redirect possible; returns to RUN.
  - A control op arriving the cycle after FLUSH is handled normally.
- Register 0:
  - Never a hazard source.
  - Untaken BEQ with rs==rt==0 is impossible; BEQ $0,$0 is always taken.
- Arithmetic:
  - beq target wraps modulo 2^32.
  - Negative immediates sign-extend from bit 15.
- Reset mid-stall or mid-FLUSH returns immediately to the reset state; no pending redirect survives.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. On a taken control op, instr_if is loaded into IF/ID (not squashed) and the FSM stays in RUN; the FLUSH state is unused.
- Undefined: squash behaviour as above.

Test Plan:
- Reset asserted mid-stream -> instr_id=0, pc_4_id_full=0, pc_src=00, pc_write=1, bubble=0 immediately, without waiting for clk.
- BEQ $1,$2,+4 at pc_4=0x0000_0104, rs_data=rt_data=5, no hazard:
  - beq=0x0000_0114, pc_src=10.
  - Next cycle instr_id=0 (macro off) or the delay-slot word (macro on).
- J 0x0000040 with pc_4_id_full=0x3000_0008 -> pc_4_id=4'h3, offset28=0x000_0100, pc_src=01, IF/ID squashed one cycle.
- LW $3 in EX followed by BEQ $3,$4:
  - 2 stall cycles: pc_write=0, bubble=1, pc_src=00.
  - Third cycle resolves with the correct comparison.
- ADD $5 in EX followed by JR $5 -> 1 stall cycle; then pc_src=11, jr=rs_data.
- LW $6 in EX followed by ADD $7,$6,$6 -> 1 bubble; no stall when ex_dst=0.
